e203_itcm_ram_arb: RTL and testbench

- Arbiter and sequencer in front of the single-port ITCM SRAM wrapper.
- Shares the SRAM between the IFU fetch port (read-only) and the LSU port (read/write).
- Keeps one transaction outstanding, holds the response until it is accepted, and drives the SRAM light-sleep pin after a programmable idle period.

---
 rtl/e203_itcm_ram_arb.sv | 170 +++++++++++++++++
 tb/tb_e203_itcm_ram_arb.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/e203_itcm_ram_arb.sv
// ITCM SRAM arbiter/sequencer: shares one single-port SRAM between IFU and LSU,
// one transaction outstanding, response hold, idle light-sleep. Macro: E203_ITCM_ARB_RR_EN.
module e203_itcm_ram_arb #(
  parameter int unsigned AW          = 13,
  parameter int unsigned DW          = 64,
  parameter int unsigned MW          = 8,
  parameter int unsigned STARVE_MAX  = 4,
  parameter int unsigned LS_IDLE_CYC = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ifu_cmd_valid,
  output logic          ifu_cmd_ready,
  input  logic [AW-1:0] ifu_cmd_addr,
  output logic          ifu_rsp_valid,
  input  logic          ifu_rsp_ready,
  output logic [DW-1:0] ifu_rsp_rdata,
  input  logic          lsu_cmd_valid,
  output logic          lsu_cmd_ready,
  input  logic          lsu_cmd_read,
  input  logic [AW-1:0] lsu_cmd_addr,
  input  logic [DW-1:0] lsu_cmd_wdata,
  input  logic [MW-1:0] lsu_cmd_wmask,
  output logic          lsu_rsp_valid,
  input  logic          lsu_rsp_ready,
  output logic [DW-1:0] lsu_rsp_rdata,
  output logic          ram_cs,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [MW-1:0] ram_wem,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic          ram_ls
);

  localparam int unsigned IDLE_CW     = 8;
  localparam logic [IDLE_CW-1:0] LS_LIM = IDLE_CW'(LS_IDLE_CYC);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_SLEEP, ST_WAKE} state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;   // 1 = LSU owns the outstanding response
  logic                wr_q, wr_d;
  logic                held_q, held_d;
  logic [DW-1:0]       hold_q, hold_d;
  logic [IDLE_CW-1:0]  idle_q, idle_d;

`ifdef E203_ITCM_ARB_RR_EN
  logic                last_q, last_d;     // 1 = LSU was granted last
`else
  localparam int unsigned STARVE_CW = 4;
  localparam logic [STARVE_CW-1:0] STARVE_LIM = STARVE_CW'(STARVE_MAX);
  logic [STARVE_CW-1:0] starve_q, starve_d;
`endif

  logic any_valid, busy, rsp_hs, can_grant, lsu_win, grant, gnt_lsu, gnt_ifu;
  logic [DW-1:0] rd_data;

  // Arbitration: grant only from IDLE or on the cycle the outstanding response retires
  always_comb begin
    any_valid = ifu_cmd_valid | lsu_cmd_valid;
    busy      = (state_q == ST_BUSY);
    rsp_hs    = busy & (owner_q ? lsu_rsp_ready : ifu_rsp_ready);
    can_grant = ~rst & ((state_q == ST_IDLE) | rsp_hs);
`ifdef E203_ITCM_ARB_RR_EN
    lsu_win   = lsu_cmd_valid & (~ifu_cmd_valid | ~last_q);
`else
    lsu_win   = lsu_cmd_valid & (~ifu_cmd_valid | (starve_q < STARVE_LIM));
`endif
    grant     = can_grant & any_valid;
    gnt_lsu   = grant & lsu_win;
    gnt_ifu   = grant & ~lsu_win;
  end

  // SRAM issue and response ports
  always_comb begin
    ifu_cmd_ready = gnt_ifu;
    lsu_cmd_ready = gnt_lsu;
    ram_cs        = grant;
    ram_we        = gnt_lsu & ~lsu_cmd_read;
    ram_addr      = gnt_lsu ? lsu_cmd_addr : (gnt_ifu ? ifu_cmd_addr : '0);
    ram_wem       = gnt_lsu ? lsu_cmd_wmask : '0;
    ram_din       = gnt_lsu ? lsu_cmd_wdata : '0;
    ram_ls        = (state_q == ST_SLEEP);
    rd_data       = held_q ? hold_q : ram_dout;
    ifu_rsp_valid = busy & ~owner_q;
    lsu_rsp_valid = busy & owner_q;
    ifu_rsp_rdata = ifu_rsp_valid ? rd_data : '0;
    lsu_rsp_rdata = (lsu_rsp_valid & ~wr_q) ? rd_data : '0;
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    wr_d    = wr_q;
    held_d  = held_q;
    hold_d  = hold_q;
    idle_d  = '0;
    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          state_d = ST_BUSY;
        end else if (!any_valid) begin
          idle_d = (idle_q == LS_LIM) ? idle_q : idle_q + IDLE_CW'(1);
          if (idle_d == LS_LIM) state_d = ST_SLEEP;
        end
      end
      ST_BUSY: begin
        if (rsp_hs) begin
          held_d  = 1'b0;
          state_d = grant ? ST_BUSY : ST_IDLE;
        end else if (!held_q) begin
          // SRAM data is only valid one cycle; keep it while the owner stalls
          held_d = 1'b1;
          hold_d = ram_dout;
        end
      end
      ST_SLEEP: if (any_valid) state_d = ST_WAKE;
      ST_WAKE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (grant) begin
      owner_d = gnt_lsu;
      wr_d    = gnt_lsu & ~lsu_cmd_read;
      held_d  = 1'b0;
    end
  end

`ifdef E203_ITCM_ARB_RR_EN
  always_comb begin
    last_d = grant ? gnt_lsu : last_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= 1'b0;
    else     last_q <= last_d;
  end
`else
  // Consecutive LSU wins while IFU is waiting
  always_comb begin
    starve_d = starve_q;
    if (!ifu_cmd_valid || gnt_ifu)            starve_d = '0;
    else if (gnt_lsu && (starve_q != '1))     starve_d = starve_q + STARVE_CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      wr_q    <= 1'b0;
      held_q  <= 1'b0;
      hold_q  <= '0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      wr_q    <= wr_d;
      held_q  <= held_d;
      hold_q  <= hold_d;
      idle_q  <= idle_d;
    end
  end

endmodule

// File: tb/tb_e203_itcm_ram_arb.sv
// Scoreboard bench for e203_itcm_ram_arb: stimulus pushes expected issues/responses,
// a negedge monitor pops and compares them; directed checks cover sleep and reset.
module tb_e203_itcm_ram_arb;

  localparam int unsigned AW = 13;
  localparam int unsigned DW = 64;
  localparam int unsigned MW = 8;

  logic          clk;
  logic          rst;
  logic          ifu_cmd_valid, ifu_cmd_ready, ifu_rsp_valid, ifu_rsp_ready;
  logic [AW-1:0] ifu_cmd_addr;
  logic [DW-1:0] ifu_rsp_rdata;
  logic          lsu_cmd_valid, lsu_cmd_ready, lsu_cmd_read, lsu_rsp_valid, lsu_rsp_ready;
  logic [AW-1:0] lsu_cmd_addr;
  logic [DW-1:0] lsu_cmd_wdata, lsu_rsp_rdata;
  logic [MW-1:0] lsu_cmd_wmask;
  logic          ram_cs, ram_we, ram_ls;
  logic [AW-1:0] ram_addr;
  logic [MW-1:0] ram_wem;
  logic [DW-1:0] ram_din, ram_dout;

  e203_itcm_ram_arb dut (
    .clk(clk), .rst(rst),
    .ifu_cmd_valid(ifu_cmd_valid), .ifu_cmd_ready(ifu_cmd_ready), .ifu_cmd_addr(ifu_cmd_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rsp_rdata(ifu_rsp_rdata),
    .lsu_cmd_valid(lsu_cmd_valid), .lsu_cmd_ready(lsu_cmd_ready), .lsu_cmd_read(lsu_cmd_read),
    .lsu_cmd_addr(lsu_cmd_addr), .lsu_cmd_wdata(lsu_cmd_wdata), .lsu_cmd_wmask(lsu_cmd_wmask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rsp_rdata(lsu_rsp_rdata),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wem(ram_wem),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_ls(ram_ls)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic          lsu;
    logic          we;
    logic [AW-1:0] addr;
    logic [MW-1:0] wem;
    logic [DW-1:0] din;
  } iss_t;

  iss_t          exp_iss[$];
  logic [DW-1:0] exp_ifu[$];
  logic [DW-1:0] exp_lsu[$];
  iss_t          e_iss;
  logic [DW-1:0] e_dat;
  int            n_cmp = 0;
  int            n_err = 0;

  localparam logic [DW-1:0] D010 = 64'hDEAD_BEEF_CAFE_F00D;
  localparam logic [DW-1:0] D100 = 64'h1111_0000_1111_0100;
  localparam logic [DW-1:0] D200 = 64'h2222_0000_2222_0200;
  localparam logic [DW-1:0] D030 = 64'h3030_A5A5_3030_5A5A;
  localparam logic [DW-1:0] D040 = 64'h4040_0404_4040_0404;
  localparam logic [DW-1:0] D050 = 64'h5050_0505_5050_0505;
  localparam logic [DW-1:0] D060 = 64'h6060_0606_6060_0606;

  // SRAM model: masked write, read data one cycle after cs; corrupt perturbs dout
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] dout_q;
  logic [DW-1:0] wtmp;
  logic          corrupt;
  assign ram_dout = corrupt ? 64'hBADB_ADBA_DBAD_BAD0 : dout_q;

  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) begin
        wtmp = mem[ram_addr];
        for (int b = 0; b < int'(MW); b++)
          if (ram_wem[b]) wtmp[b*8 +: 8] = ram_din[b*8 +: 8];
        mem[ram_addr] <= wtmp;
      end else begin
        dout_q <= mem[ram_addr];
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_iss(input logic lsu, input logic we, input logic [AW-1:0] addr,
                          input logic [MW-1:0] wem, input logic [DW-1:0] din);
    iss_t t;
    t.lsu = lsu; t.we = we; t.addr = addr; t.wem = wem; t.din = din;
    exp_iss.push_back(t);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every SRAM issue and every response handshake is checked against the queues
  always @(negedge clk) begin
    if (!rst) begin
      if (ram_cs) begin
        if (exp_iss.size() == 0) begin
          chk("issue_unexpected", 64'(ram_addr), 64'h1_0000);
        end else begin
          e_iss = exp_iss.pop_front();
          chk("issue_lsu_ready", 64'(lsu_cmd_ready), 64'(e_iss.lsu));
          chk("issue_ifu_ready", 64'(ifu_cmd_ready), 64'(!e_iss.lsu));
          chk("issue_we", 64'(ram_we), 64'(e_iss.we));
          chk("issue_addr", 64'(ram_addr), 64'(e_iss.addr));
          chk("issue_wem", 64'(ram_wem), 64'(e_iss.wem));
          chk("issue_din", ram_din, e_iss.din);
        end
      end
      if (ifu_rsp_valid && lsu_rsp_valid) chk("rsp_both_valid", 64'd1, 64'd0);
      if (ifu_rsp_valid && ifu_rsp_ready) begin
        if (exp_ifu.size() == 0) chk("ifu_rsp_unexpected", ifu_rsp_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          e_dat = exp_ifu.pop_front();
          chk("ifu_rsp_rdata", ifu_rsp_rdata, e_dat);
        end
      end
      if (lsu_rsp_valid && lsu_rsp_ready) begin
        if (exp_lsu.size() == 0) chk("lsu_rsp_unexpected", lsu_rsp_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          e_dat = exp_lsu.pop_front();
          chk("lsu_rsp_rdata", lsu_rsp_rdata, e_dat);
        end
      end
    end
  end

  initial begin
    logic l;
    rst = 1'b1;
    corrupt = 1'b0;
    dout_q = '0;
    ifu_cmd_valid = 1'b0; ifu_cmd_addr = '0; ifu_rsp_ready = 1'b1;
    lsu_cmd_valid = 1'b0; lsu_cmd_read = 1'b1; lsu_cmd_addr = '0;
    lsu_cmd_wdata = '0; lsu_cmd_wmask = '0; lsu_rsp_ready = 1'b1;
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    mem[13'h010] = D010; mem[13'h100] = D100; mem[13'h200] = D200;
    mem[13'h030] = D030; mem[13'h040] = D040; mem[13'h050] = D050; mem[13'h060] = D060;

    // Reset state, with a request present that must not be granted
    repeat (2) cyc();
    ifu_cmd_valid = 1'b1; ifu_cmd_addr = 13'h123;
    #1;
    chk("rst_ram_cs", 64'(ram_cs), 64'd0);
    chk("rst_cmd_ready", 64'({ifu_cmd_ready, lsu_cmd_ready}), 64'd0);
    chk("rst_rsp_valid", 64'({ifu_rsp_valid, lsu_rsp_valid}), 64'd0);
    chk("rst_we_ls", 64'({ram_we, ram_ls}), 64'd0);
    chk("rst_ram_bus", 64'({ram_addr, ram_wem}) | ram_din, 64'd0);
    chk("rst_rdata", ifu_rsp_rdata | lsu_rsp_rdata, 64'd0);
    ifu_cmd_valid = 1'b0; ifu_cmd_addr = '0;
    cyc();
    rst = 1'b0;
    cyc();

    // Single IFU read
    push_iss(1'b0, 1'b0, 13'h010, 8'h00, 64'd0);
    exp_ifu.push_back(D010);
    ifu_cmd_valid = 1'b1; ifu_cmd_addr = 13'h010;
    cyc();
    ifu_cmd_valid = 1'b0;
    cyc();

    // Both requesters valid for 10 back-to-back grants
    for (int i = 0; i < 10; i++) begin
`ifdef E203_ITCM_ARB_RR_EN
      l = (i % 2 == 0);
`else
      l = (i % 5 != 4);
`endif
      push_iss(l, 1'b0, l ? 13'h200 : 13'h100, 8'h00, 64'd0);
      if (l) exp_lsu.push_back(D200);
      else   exp_ifu.push_back(D100);
    end
    ifu_cmd_valid = 1'b1; ifu_cmd_addr = 13'h100;
    lsu_cmd_valid = 1'b1; lsu_cmd_read = 1'b1; lsu_cmd_addr = 13'h200;
    repeat (10) cyc();
    ifu_cmd_valid = 1'b0; lsu_cmd_valid = 1'b0;
    cyc();

    // LSU masked write then read-back, issued back to back
    push_iss(1'b1, 1'b1, 13'h020, 8'h0F, 64'h1122_3344_5566_7788);
    exp_lsu.push_back(64'd0);
    push_iss(1'b1, 1'b0, 13'h020, 8'h00, 64'd0);
    exp_lsu.push_back(64'h0000_0000_5566_7788);
    lsu_cmd_valid = 1'b1; lsu_cmd_read = 1'b0; lsu_cmd_addr = 13'h020;
    lsu_cmd_wdata = 64'h1122_3344_5566_7788; lsu_cmd_wmask = 8'h0F;
    cyc();
    lsu_cmd_read = 1'b1; lsu_cmd_wdata = '0; lsu_cmd_wmask = '0;
    cyc();
    lsu_cmd_valid = 1'b0;
    cyc();

    // Backpressure: response held while the SRAM output changes
    push_iss(1'b1, 1'b0, 13'h030, 8'h00, 64'd0);
    exp_lsu.push_back(D030);
    lsu_cmd_valid = 1'b1; lsu_cmd_addr = 13'h030;
    cyc();
    lsu_cmd_valid = 1'b0; lsu_rsp_ready = 1'b0;
    @(negedge clk);
    chk("bp_rsp_valid_c1", 64'(lsu_rsp_valid), 64'd1);
    chk("bp_rdata_c1", lsu_rsp_rdata, D030);
    cyc();
    corrupt = 1'b1;
    for (int k = 2; k <= 3; k++) begin
      @(negedge clk);
      chk("bp_rdata_held", lsu_rsp_rdata, D030);
      chk("bp_no_cs", 64'({ram_cs, lsu_rsp_valid}), 64'd1);
      cyc();
    end
    lsu_rsp_ready = 1'b1;
    cyc();
    corrupt = 1'b0;

    // Sleep after 16 idle cycles, then a two-cycle wake before the grant
    repeat (15) cyc();
    @(negedge clk);
    chk("sleep_ls_at_16", 64'(ram_ls), 64'd0);
    cyc();
    @(negedge clk);
    chk("sleep_ls_set", 64'(ram_ls), 64'd1);
    cyc();
    push_iss(1'b0, 1'b0, 13'h040, 8'h00, 64'd0);
    exp_ifu.push_back(D040);
    ifu_cmd_valid = 1'b1; ifu_cmd_addr = 13'h040;
    @(negedge clk);
    chk("sleep_ready_c1", 64'({ifu_cmd_ready, ram_cs}), 64'd0);
    chk("sleep_ls_c1", 64'(ram_ls), 64'd1);
    cyc();
    @(negedge clk);
    chk("wake_ready_c2", 64'({ifu_cmd_ready, ram_cs}), 64'd0);
    chk("wake_ls_c2", 64'(ram_ls), 64'd0);
    cyc();
    @(negedge clk);
    chk("wake_grant_c3", 64'(ifu_cmd_ready), 64'd1);
    cyc();
    ifu_cmd_valid = 1'b0;
    cyc();

    // Reset while a response is pending and another request waits
    push_iss(1'b1, 1'b0, 13'h050, 8'h00, 64'd0);
    lsu_cmd_valid = 1'b1; lsu_cmd_addr = 13'h050;
    cyc();
    lsu_rsp_ready = 1'b0;
    @(negedge clk);
    chk("busy_rsp_valid", 64'(lsu_rsp_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_rsp_valid", 64'({lsu_rsp_valid, ifu_rsp_valid}), 64'd0);
    chk("midrst_cs_ready", 64'({ram_cs, lsu_cmd_ready}), 64'd0);
    chk("midrst_rdata", lsu_rsp_rdata, 64'd0);
    chk("midrst_addr", 64'(ram_addr), 64'd0);
    cyc();
    cyc();
    rst = 1'b0; lsu_cmd_valid = 1'b0; lsu_rsp_ready = 1'b1;
    @(negedge clk);
    chk("postrst_rsp_valid", 64'(lsu_rsp_valid), 64'd0);
    cyc();
    push_iss(1'b0, 1'b0, 13'h060, 8'h00, 64'd0);
    exp_ifu.push_back(D060);
    ifu_cmd_valid = 1'b1; ifu_cmd_addr = 13'h060;
    cyc();
    ifu_cmd_valid = 1'b0;
    repeat (2) cyc();

    chk("left_issues", 64'(exp_iss.size()), 64'd0);
    chk("left_ifu_rsp", 64'(exp_ifu.size()), 64'd0);
    chk("left_lsu_rsp", 64'(exp_lsu.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
